// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: frame header bytes,
// arbiter state encoding and the header legality check.
package uart_pkg;

    localparam int FRAME_W = 56;

    localparam logic [7:0] UART_SG_ADS_SEND_DATA = 8'hAA;
    localparam logic [7:0] UART_SG_ADS_READ_REG  = 8'h61;
    localparam logic [7:0] UART_SG_MPR_READ_REG  = 8'h6D;
    localparam logic [7:0] UART_SG_MPR_SEND_DATA = 8'hBB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } arb_state_t;

    // Only these headers are forwarded to uart_controller; anything else is dropped.
    function automatic logic header_legal(input logic [7:0] hdr);
        return (hdr == UART_SG_ADS_SEND_DATA) ||
               (hdr == UART_SG_ADS_READ_REG)  ||
               (hdr == UART_SG_MPR_READ_REG);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester favoured on
// a tie; after every advance it moves to the side that did not win.
module rr_arb2 (
    input  logic       i_CLK,
    input  logic       i_RSTN,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    // Grant the favoured requester if it asks, otherwise the other one.
    always_comb begin
        gnt = 2'b00;
        if (!ptr) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

    // Pointer moves to the loser of each consumed grant; reset favours req[0].
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN)
            ptr <= 1'b0;
        else if (advance && (gnt != 2'b00))
            ptr <= gnt[0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the 56-bit uart_controller TX frame port among REG, ADS and MPR
// sources. REG has fixed priority; ADS and MPR alternate via rr_arb2.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to abort a transfer that
// stays in ST_REQ/ST_SEND for TIMEOUT_CYCLES cycles.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no frame in flight; grants allowed while controller ready
//   ST_REQ  | TX valid high, waiting for controller to drop ready
//   ST_SEND | controller busy with the frame, waiting for ready again
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic               i_CLK,
    input  logic               i_RSTN,
    input  logic [FRAME_W-1:0] i_REG_DATA,
    input  logic               i_REG_VALID,
    output logic               o_REG_READY,
    input  logic [FRAME_W-1:0] i_ADS_DATA,
    input  logic               i_ADS_VALID,
    output logic               o_ADS_READY,
    input  logic [FRAME_W-1:0] i_MPR_DATA,
    input  logic               i_MPR_VALID,
    output logic               o_MPR_READY,
    output logic [FRAME_W-1:0] o_UART_DATA_TX,
    output logic               o_UART_DATA_TX_VALID,
    input  logic               i_UART_DATA_TX_READY,
    output logic               o_BUSY,
    output logic               o_DROP,
    output logic               o_TIMEOUT
);

    arb_state_t         state;
    logic [FRAME_W-1:0] frame_q;
    logic               tx_valid_q;
    logic               drop_q;
    logic               timeout_q;

    logic               grant_ok;
    logic [1:0]         pair_gnt;
    logic               reg_take;
    logic               ads_take;
    logic               mpr_take;
    logic               any_take;
    logic [FRAME_W-1:0] win_data;
    logic               timeout_hit;

    // Reset is folded in so no source sees READY while the block is held in reset.
    assign grant_ok = (state == ST_IDLE) && i_UART_DATA_TX_READY && i_RSTN;

    rr_arb2 u_rr_arb2 (
        .i_CLK   (i_CLK),
        .i_RSTN  (i_RSTN),
        .req     ({i_MPR_VALID, i_ADS_VALID}),
        .advance (ads_take || mpr_take),
        .gnt     (pair_gnt)
    );

    assign reg_take = grant_ok && i_REG_VALID;
    assign ads_take = grant_ok && !i_REG_VALID && pair_gnt[0];
    assign mpr_take = grant_ok && !i_REG_VALID && pair_gnt[1];
    assign any_take = reg_take || ads_take || mpr_take;

    // Frame of whichever source wins this cycle.
    always_comb begin
        win_data = i_MPR_DATA;
        if (reg_take)
            win_data = i_REG_DATA;
        else if (ads_take)
            win_data = i_ADS_DATA;
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Counts cycles spent outside ST_IDLE; zero on the first ST_REQ cycle.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN)
            tmo_cnt <= '0;
        else if (state == ST_IDLE)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign timeout_hit = (state != ST_IDLE) && (tmo_cnt == (TIMEOUT_CYCLES - 16'd1));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
`endif

    // Transfer sequencing with registered TX valid, drop and timeout pulses.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state      <= ST_IDLE;
            frame_q    <= '0;
            tx_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (timeout_hit) begin
                state      <= ST_IDLE;
                tx_valid_q <= 1'b0;
                timeout_q  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_take) begin
                            frame_q <= win_data;
                            if (header_legal(win_data[FRAME_W-1 -: 8])) begin
                                state      <= ST_REQ;
                                tx_valid_q <= 1'b1;
                            end else begin
                                drop_q <= 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (!i_UART_DATA_TX_READY) begin
                            state      <= ST_SEND;
                            tx_valid_q <= 1'b0;
                        end
                    end
                    ST_SEND: begin
                        if (i_UART_DATA_TX_READY)
                            state <= ST_IDLE;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        tx_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_REG_READY          = reg_take;
    assign o_ADS_READY          = ads_take;
    assign o_MPR_READY          = mpr_take;
    assign o_UART_DATA_TX       = frame_q;
    assign o_UART_DATA_TX_VALID = tx_valid_q;
    assign o_BUSY               = (state != ST_IDLE);
    assign o_DROP               = drop_q;
    assign o_TIMEOUT            = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: reset table, directed sequences and randomized
// traffic against a transaction-level model with a simple controller model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int S_REG  = 0;
    localparam int S_ADS  = 1;
    localparam int S_MPR  = 2;
    localparam int S_NONE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [55:0] reg_d, ads_d, mpr_d;
    logic        reg_v, ads_v, mpr_v;
    logic        reg_r, ads_r, mpr_r;
    logic [55:0] tx_d;
    logic        tx_v;
    logic        uart_rdy;
    logic        busy, drop, tmo;

    always #5 clk = ~clk;

`ifdef UART_TX_ARB_TIMEOUT_EN
    uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd20)) dut (
`else
    uart_tx_arbiter dut (
`endif
        .i_CLK(clk), .i_RSTN(rst_n),
        .i_REG_DATA(reg_d), .i_REG_VALID(reg_v), .o_REG_READY(reg_r),
        .i_ADS_DATA(ads_d), .i_ADS_VALID(ads_v), .o_ADS_READY(ads_r),
        .i_MPR_DATA(mpr_d), .i_MPR_VALID(mpr_v), .o_MPR_READY(mpr_r),
        .o_UART_DATA_TX(tx_d), .o_UART_DATA_TX_VALID(tx_v),
        .i_UART_DATA_TX_READY(uart_rdy),
        .o_BUSY(busy), .o_DROP(drop), .o_TIMEOUT(tmo)
    );

    int n_vec = 0;
    int n_bad = 0;

    // model state
    bit          m_inflight;
    bit          m_valid_exp;
    bit          m_drop_exp;
    bit          mpr_next;
    logic [55:0] exp_q[$];
    int          glog[$];
    bit          ctl_auto;
    int          ctl_hold;

    typedef struct {
        logic       reg_v, ads_v, mpr_v, rdy;
        logic [7:0] hdr;
        logic [2:0] exp_rdy;
        logic       exp_valid, exp_drop;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [7:0] h);
        return (h == 8'hAA) || (h == 8'h61) || (h == 8'h6D);
    endfunction

    function automatic int model_winner();
        if (m_inflight || !uart_rdy) return S_NONE;
        if (reg_v) return S_REG;
        if (ads_v && mpr_v) return mpr_next ? S_MPR : S_ADS;
        if (ads_v) return S_ADS;
        if (mpr_v) return S_MPR;
        return S_NONE;
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_valid_exp = 0; m_drop_exp = 0; mpr_next = 0;
        exp_q.delete(); glog.delete();
        ctl_hold = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reg_v = 0; ads_v = 0; mpr_v = 0;
        uart_rdy = 1'b1; ctl_auto = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: check pre-edge outputs, advance model and controller.
    task automatic cycle();
        int          w;
        logic [2:0]  er;
        logic        cap;
        logic [55:0] cap_d, fr;
        bit          old_v, old_i;
        #1;
        w  = model_winner();
        er = (w == S_REG) ? 3'b100 : (w == S_ADS) ? 3'b010 : (w == S_MPR) ? 3'b001 : 3'b000;
        chk("src_ready", 64'({reg_r, ads_r, mpr_r}), 64'(er));
        chk("tx_valid", 64'(tx_v), 64'(m_valid_exp));
        chk("busy", 64'(busy), 64'(m_inflight));
        chk("drop", 64'(drop), 64'(m_drop_exp));
`ifndef UART_TX_ARB_TIMEOUT_EN
        chk("timeout_off", 64'(tmo), 64'd0);
`endif
        cap   = tx_v && uart_rdy;
        cap_d = tx_d;
        fr    = (w == S_REG) ? reg_d : (w == S_ADS) ? ads_d : mpr_d;
        @(posedge clk); #1;
        old_v = m_valid_exp; old_i = m_inflight;
        m_drop_exp = 0;
        if (old_v && !uart_rdy) m_valid_exp = 0;
        if (old_i && !old_v && uart_rdy) m_inflight = 0;
        if (w != S_NONE) begin
            glog.push_back(w);
            if (w == S_REG) reg_v = 0;
            if (w == S_ADS) begin ads_v = 0; mpr_next = 1; end
            if (w == S_MPR) begin mpr_v = 0; mpr_next = 0; end
            if (legal(fr[55:48])) begin
                m_inflight = 1; m_valid_exp = 1; exp_q.push_back(fr);
            end else begin
                m_drop_exp = 1;
            end
        end
        if (cap) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL tx_frame: got %0h expected no frame", cap_d);
            end else begin
                chk("tx_frame", 64'(cap_d), 64'(exp_q.pop_front()));
            end
            uart_rdy = 0;
            ctl_hold = $urandom_range(1, 4);
        end else if (ctl_auto && !uart_rdy) begin
            ctl_hold--;
            if (ctl_hold <= 0) uart_rdy = 1;
        end
    endtask

    task automatic drain();
        reg_v = 0; ads_v = 0; mpr_v = 0;
        ctl_auto = 1;
        for (int i = 0; i < 100 && (m_inflight || m_drop_exp || !uart_rdy); i++) cycle();
        cycle();
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [55:0] rand_frame(input logic [7:0] h);
        return {h, 16'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [7:0] rand_hdr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 8'hAA;
        if (r < 6) return 8'h61;
        if (r < 9) return 8'h6D;
        return 8'hBB;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1);
    end

    initial begin
        int exp_ord[4];
        int cnt;

        // reset state: everything low even with all sources pending
        rst_n = 0; uart_rdy = 1; ctl_auto = 1;
        reg_d = rand_frame(8'h61); ads_d = rand_frame(8'hAA); mpr_d = rand_frame(8'h6D);
        reg_v = 1; ads_v = 1; mpr_v = 1;
        #2;
        chk("rst_ready", 64'({reg_r, ads_r, mpr_r}), 64'd0);
        chk("rst_valid", 64'(tx_v), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_timeout", 64'(tmo), 64'd0);
        @(posedge clk); #1;
        chk("rst_data", 64'(tx_d), 64'd0);

        // single-cycle grant table, each row from a fresh reset
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h61, 3'b100, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 3'b010, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h6D, 3'b001, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 3'b010, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 3'b100, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 3'b000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 3'b000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hBB, 3'b100, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hBB, 3'b001, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'b010, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h6D, 3'b100, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            do_reset();
            uart_rdy = tbl[i].rdy;
            reg_d = {tbl[i].hdr, 48'h0123456789AB};
            ads_d = {tbl[i].hdr, 48'hA5A5A5A5A5A5};
            mpr_d = {tbl[i].hdr, 48'h5A5A5A5A5A5A};
            reg_v = tbl[i].reg_v; ads_v = tbl[i].ads_v; mpr_v = tbl[i].mpr_v;
            #1;
            chk("tbl_ready", 64'({reg_r, ads_r, mpr_r}), 64'(tbl[i].exp_rdy));
            @(posedge clk); #1;
            reg_v = 0; ads_v = 0; mpr_v = 0;
            chk("tbl_valid", 64'(tx_v), 64'(tbl[i].exp_valid));
            chk("tbl_busy", 64'(busy), 64'(tbl[i].exp_valid));
            chk("tbl_drop", 64'(drop), 64'(tbl[i].exp_drop));
        end

        // REG frame end to end
        do_reset();
        reg_d = 56'h610A5500C3A5F0; reg_v = 1;
        cycle();
        drain();
        chk("t1_grant", 64'(glog.size() > 0 ? glog[0] : S_NONE), 64'(S_REG));
        chk("t1_hold", 64'(tx_d), 64'h610A5500C3A5F0);

        // ADS and MPR both always pending alternate
        do_reset();
        ads_d = rand_frame(8'hAA); mpr_d = rand_frame(8'h6D);
        ads_v = 1; mpr_v = 1;
        for (int i = 0; i < 200 && glog.size() < 4; i++) begin
            cycle();
            if (!ads_v) begin ads_d = rand_frame(8'hAA); ads_v = 1; end
            if (!mpr_v) begin mpr_d = rand_frame(8'h6D); mpr_v = 1; end
        end
        exp_ord = '{S_ADS, S_MPR, S_ADS, S_MPR};
        chk("t2_count", 64'(glog.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++)
            chk("t2_order", 64'(i < glog.size() ? glog[i] : S_NONE), 64'(exp_ord[i]));
        drain();

        // all three at once
        do_reset();
        reg_d = rand_frame(8'h61); ads_d = rand_frame(8'hAA); mpr_d = rand_frame(8'h6D);
        reg_v = 1; ads_v = 1; mpr_v = 1;
        for (int i = 0; i < 200 && glog.size() < 3; i++) cycle();
        exp_ord = '{S_REG, S_ADS, S_MPR, S_NONE};
        for (int i = 0; i < 3; i++)
            chk("t3_order", 64'(i < glog.size() ? glog[i] : S_NONE), 64'(exp_ord[i]));
        drain();

        // reset while in ST_REQ, then controller not ready after release
        do_reset();
        ctl_auto = 0;
        reg_d = rand_frame(8'h61); reg_v = 1;
        cycle();
        #1;
        chk("t5_valid_before", 64'(tx_v), 64'd1);
        rst_n = 0;
        #1;
        chk("t5_valid_rst", 64'(tx_v), 64'd0);
        chk("t5_busy_rst", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        uart_rdy = 0; ctl_auto = 0;
        reg_d = rand_frame(8'h61); ads_d = rand_frame(8'hAA); mpr_d = rand_frame(8'h6D);
        reg_v = 1; ads_v = 1; mpr_v = 1;
        for (int i = 0; i < 5; i++) cycle();
        chk("t5_no_grant", 64'(glog.size()), 64'd0);
        uart_rdy = 1; ctl_auto = 1;
        cycle();
        chk("t5_grant", 64'(glog.size() > 0 ? glog[0] : S_NONE), 64'(S_REG));
        drain();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (!reg_v && $urandom_range(0, 7) == 0) begin reg_d = rand_frame(rand_hdr()); reg_v = 1; end
            if (!ads_v && $urandom_range(0, 2) == 0) begin ads_d = rand_frame(rand_hdr()); ads_v = 1; end
            if (!mpr_v && $urandom_range(0, 2) == 0) begin mpr_d = rand_frame(rand_hdr()); mpr_v = 1; end
            cycle();
        end
        drain();

`ifdef UART_TX_ARB_TIMEOUT_EN
        // controller never drops ready: abort after 20 cycles
        do_reset();
        reg_d = rand_frame(8'hAA); reg_v = 1; uart_rdy = 1;
        #1;
        chk("t6_ready", 64'(reg_r), 64'd1);
        @(posedge clk); #1;
        reg_v = 0;
        cnt = 0;
        for (int i = 0; i < 40 && tx_v; i++) begin
            chk("t6_no_early_timeout", 64'(tmo), 64'd0);
            cnt++;
            @(posedge clk); #1;
        end
        chk("t6_valid_cycles", 64'(cnt), 64'd20);
        chk("t6_timeout", 64'(tmo), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("t6_timeout_pulse", 64'(tmo), 64'd0);
`endif

        cnt = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
